// File: rtl/ega_scanout.sv
// EGA raster scan-out: hc/vc timing, 4bpp VRAM fetch (two pixels per byte) and a
// two-step pipeline that keeps sync, blanking and palette index aligned.
module ega_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 350,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 60,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic              enable,
    input  logic [3:0]        border_index,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    input  logic [7:0]        vram_data,
    output logic [3:0]        pixel_index,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HC_W-1:0]   hc;
    logic [VC_W-1:0]   vc;
    logic [ADDR_W-1:0] lin_addr;
    logic              en_frame;

    logic              at_origin;
    logic              visible;
    logic              hs_now;
    logic              vs_now;
    logic              en_eff;
    logic              fetch;
    logic [ADDR_W-1:0] addr_eff;

    logic              s1_visible;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_sel;
    logic              s1_en;
    logic              s1_first;

    // At (0,0) the frame enable and the address restart take effect in the same
    // step, so pixel (0,0) already uses the freshly sampled enable and address 0.
    always_comb begin
        at_origin = (hc == '0) && (vc == '0);
        visible   = (hc < H_VIS) && (vc < V_VIS);
        hs_now    = (hc >= HS_BEG) && (hc < HS_END);
        vs_now    = (vc >= VS_BEG) && (vc < VS_END);
        en_eff    = at_origin ? enable : en_frame;
        addr_eff  = at_origin ? '0 : lin_addr;
        fetch     = visible && !hc[0] && en_eff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc       <= '0;
            vc       <= '0;
            lin_addr <= '0;
            en_frame <= 1'b0;
        end else if (pix_ce) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
            en_frame <= en_eff;
            lin_addr <= fetch ? addr_eff + 1'b1 : addr_eff;
        end
    end

    // Step 1: VRAM request and decoded position attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_rd    <= 1'b0;
            vram_addr  <= '0;
            s1_visible <= 1'b0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_sel     <= 1'b0;
            s1_en      <= 1'b0;
            s1_first   <= 1'b0;
        end else begin
            vram_rd <= pix_ce && fetch;
            if (pix_ce) begin
                if (fetch) begin
                    vram_addr <= addr_eff;
                end
                s1_visible <= visible;
                s1_hs      <= hs_now;
                s1_vs      <= vs_now;
                s1_sel     <= hc[0];
                s1_en      <= en_eff;
                s1_first   <= at_origin;
            end
        end
    end

    // Step 2: pixel mux and aligned timing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_index <= 4'h0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            if (!s1_visible) begin
                pixel_index <= 4'h0;
            end else if (s1_en) begin
                pixel_index <= s1_sel ? vram_data[3:0] : vram_data[7:4];
            end else begin
                pixel_index <= border_index;
            end
            hsync       <= s1_hs ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
            active      <= s1_visible;
            frame_start <= s1_first;
        end
    end

endmodule

// File: tb/tb_ega_scanout.sv
// Directed bench for ega_scanout on a 14x7 raster (8x4 visible); expected
// outputs come from a position-based reference of the raster and VRAM contents.
module tb_ega_scanout;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_ce = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] border_index = 4'h9;
    logic [7:0] vram_addr;
    logic       vram_rd;
    logic [7:0] vram_data;
    logic [7:0] vram_hold = 8'h00;
    logic [3:0] pixel_index;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       frame_start;

    int n_cmp = 0;
    int n_err = 0;
    bit en_tab [0:7];
    int rd_cnt [0:7];
    int last_fs;

    ega_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .ADDR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_ce(pix_ce),
        .enable(enable),
        .border_index(border_index),
        .vram_addr(vram_addr),
        .vram_rd(vram_rd),
        .vram_data(vram_data),
        .pixel_index(pixel_index),
        .hsync(hsync),
        .vsync(vsync),
        .active(active),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return {a[3:0], ~a[3:0]};
    endfunction

    // VRAM: data for the registered address is valid while vram_rd is high and
    // is held afterwards until the next read.
    assign vram_data = vram_rd ? mem_byte(vram_addr) : vram_hold;
    always @(posedge clk) if (vram_rd) vram_hold <= mem_byte(vram_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_pix(input int p);
        int hc = p % 14;
        int vc = (p / 14) % 7;
        logic [7:0] a;
        if (!(hc < 8 && vc < 4)) return 4'h0;
        if (!en_tab[p / 98]) return 4'h9;
        a = 8'(vc * 4 + hc / 2);
        return (hc % 2 == 1) ? ~a[3:0] : a[3:0];
    endfunction

    function automatic bit exp_fetch(input int q);
        int hc = q % 14;
        int vc = (q / 14) % 7;
        return (hc < 8) && (vc < 4) && (hc % 2 == 0) && en_tab[q / 98];
    endfunction

    function automatic logic [7:0] exp_addr(input int q);
        int hc = q % 14;
        int vc = (q / 14) % 7;
        return 8'(vc * 4 + hc / 2);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_pixel"}, 32'(pixel_index), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd0);
        chk({tag, "_rd"}, 32'(vram_rd), 32'd0);
        chk({tag, "_addr"}, 32'(vram_addr), 32'd0);
    endtask

    // One pixel step: step s processes raster position s-1 and outputs s-2.
    task automatic step(input int period, input int s);
        int p = s - 2;
        int q = s - 1;
        int hc;
        int vc;
        pix_ce = 1'b1;
        @(posedge clk); #1;
        if (period > 1) pix_ce = 1'b0;
        if (p < 0) begin
            chk("first_pixel", 32'(pixel_index), 32'd0);
            chk("first_active", 32'(active), 32'd0);
            chk("first_fs", 32'(frame_start), 32'd0);
            chk("first_hsync", 32'(hsync), 32'd1);
            chk("first_vsync", 32'(vsync), 32'd0);
        end else begin
            hc = p % 14;
            vc = (p / 14) % 7;
            chk("pixel_index", 32'(pixel_index), 32'(exp_pix(p)));
            chk("active", 32'(active), 32'(hc < 8 && vc < 4));
            chk("hsync", 32'(hsync), 32'(!(hc >= 10 && hc < 12)));
            chk("vsync", 32'(vsync), 32'(vc == 5));
            chk("frame_start", 32'(frame_start), 32'(p % 98 == 0));
            if (frame_start) begin
                if (last_fs >= 0) chk("fs_period", 32'(s - last_fs), 32'd98);
                last_fs = s;
            end
        end
        chk("vram_rd", 32'(vram_rd), 32'(exp_fetch(q)));
        if (vram_rd) begin
            rd_cnt[q / 98]++;
            chk("vram_addr", 32'(vram_addr), 32'(exp_addr(q)));
        end
        repeat (period - 1) begin
            @(posedge clk); #1;
            chk("vram_rd_width", 32'(vram_rd), 32'd0);
        end
    endtask

    task automatic clear_run(input bit f1);
        for (int i = 0; i < 8; i++) begin
            en_tab[i] = 1'b1;
            rd_cnt[i] = 0;
        end
        en_tab[1] = f1;
        last_fs = -1;
    endtask

    initial begin
        // Run 1: constant pix_ce, enable dropped mid frame 0, restored mid frame 1.
        clear_run(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        for (int s = 1; s <= 392; s++) begin
            enable = ((s - 1) < 50) || ((s - 1) >= 148);
            step(1, s);
        end
        chk("rd_count_f0", 32'(rd_cnt[0]), 32'd16);
        chk("rd_count_f1", 32'(rd_cnt[1]), 32'd0);
        chk("rd_count_f2", 32'(rd_cnt[2]), 32'd16);

        // Run 2: pix_ce asserted one clk in three.
        rst = 1'b1;
        pix_ce = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        check_reset("reset2");
        rst = 1'b0;
        clear_run(1'b1);
        for (int s = 1; s <= 197; s++) step(3, s);
        chk("rd_count_ce3_f0", 32'(rd_cnt[0]), 32'd16);
        chk("rd_count_ce3_f1", 32'(rd_cnt[1]), 32'd16);

        // Run 3: reset asserted with counters at (hc=5, vc=2).
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_run(1'b1);
        for (int s = 1; s <= 33; s++) step(1, s);
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge clk); #1;
        check_reset("mid_reset_hold");
        rst = 1'b0;
        clear_run(1'b1);
        for (int s = 1; s <= 20; s++) step(1, s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ega_scanout.md
# ega_scanout

Raster scan-out engine for the EGA display path. Generates horizontal/vertical timing, reads 4-bit-per-pixel video memory (two pixels per byte), and emits a 4-bit palette index each pixel. The index feeds the EGA colour palette lookup, which produces the 6-bit rgbRGB output. All outputs share one pipeline delay, so sync, blanking and pixel data stay aligned.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be even)
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 350, visible lines per frame
- V_FP, 37, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 60, vertical back porch, in lines
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync
- ADDR_W, 17, VRAM byte-address width (must hold H_ACTIVE*V_ACTIVE/2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- pix_ce  in  1  pixel clock enable; the pipeline advances only on clk edges where pix_ce=1
- enable  in  1  display enable; sampled at frame boundary
- border_index  in  4  index driven for active pixels while display is disabled
- vram_addr  out  ADDR_W  byte address to VRAM
- vram_rd  out  1  VRAM read strobe
- vram_data  in  8  VRAM read data; high nibble = even pixel, low nibble = odd pixel
- pixel_index  out  4  palette index
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  visible-area flag
- frame_start  out  1  one-step pulse aligned with pixel (0,0)

## Operation

- Line length H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. Frame length V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters hc/vc:
  - hc increments on each pix_ce and wraps H_TOTAL-1 -> 0.
  - On that wrap, vc increments; vc wraps V_TOTAL-1 -> 0.
- Region decode on the counters:
  - Visible: hc<H_ACTIVE and vc<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
  - All other counter values drive the inactive level (HSYNC_POL/VSYNC_POL define the asserted level).
- en_frame latch: loaded from enable on the pix_ce where the counters are at (0,0). It holds for the whole frame, so enable changes never tear a frame.
- Fetch:
  - Condition: visible, hc even, and en_frame=1.
  - Action: vram_rd=1 for that step, vram_addr = linear address, and the linear address increments by 1 afterwards.
  - The linear address resets to 0 at (0,0). It is not reset per line: lines are contiguous, H_ACTIVE/2 bytes each.
- Pixel select: hc bit 0 is pipelined with the fetch. Even hc selects vram_data[7:4]; odd hc selects vram_data[3:0].
- Output mux:
  - visible and en_frame=1: selected nibble
  - visible and en_frame=0: border_index
  - not visible: 0
- VRAM contract: synchronous read, data valid one clk after vram_rd and held until the next read. The block samples vram_data only on pix_ce steps.

## Timing

- Two-step pipeline, counted in pix_ce steps.
  - Step 1 (counter state at (hc,vc)): registers vram_addr/vram_rd, visible flag, sync levels, nibble select.
  - Step 2: registers pixel_index, hsync, vsync, active, frame_start.
  - Outputs for position (hc,vc) appear after the 2nd pix_ce edge following the step in which the counters hold (hc,vc).
- vram_rd is a registered pulse asserted for exactly one clk, even when pix_ce is held high continuously. It is never asserted outside the visible area.
- pix_ce=0: all registers hold, and vram_rd deasserts after one clk.
- frame_start is high for exactly one pix_ce step, coincident with the output of pixel (0,0).
- Reset state (asynchronous assert):
  - hc=vc=0, linear address 0, en_frame=0.
  - vram_rd=0, vram_addr=0, pixel_index=0, active=0, frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Reset deassertion: the first pix_ce step processes (0,0). en_frame samples enable at that step.
- Reset mid-frame: state returns immediately to the reset state and any in-flight fetch is discarded. The next frame restarts from address 0.

## Test plan

Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), pix_ce=1 constantly, POL=0/1, VRAM preloaded with byte k = {k[3:0], ~k[3:0]}, enable=1 before reset release.

- Reset release -> pixel (0,0) outputs 2 steps later: frame_start=1, active=1, pixel_index=0x0, then 0xF. Line 0 fetch addresses 0,1,2,3.
- Full frame -> exactly 16 vram_rd pulses, addresses 0..15. Line 1 begins at address 4. Frame 2 restarts at 0. frame_start period = 98 steps.
- Sync windows -> hsync low for output hc 10..11 of every line. vsync high for output vc 5 (14 steps). active high 8 of 14 steps on lines 0..3.
- enable dropped mid-frame 0, border_index=0x9 -> frame 0 completes with VRAM data. Frame 1 outputs 0x9 on all 32 visible pixels with zero vram_rd pulses. Re-asserting enable resumes VRAM data from the next frame.
- pix_ce toggling 1-of-3 clks -> output sequence identical to the constant case. Each vram_rd is 1 clk wide.
- rst asserted at (hc=5, vc=2) -> outputs take reset values in the same cycle. After release, address 0 is fetched at (0,0).
